// File: rtl/pv2byp_hazard_sched.sv
// Pipeline control for the 5-stage PARCv2 bypass datapath: destination tracking
// in X/M/W, operand bypass selection, load-use / muldiv-use hazards, muldiv
// val/rdy sequencing, per-stage stalls and W-stage regfile write control.
module pv2byp_hazard_sched #(
    parameter int unsigned NREGS  = 32,
    parameter bit          BYP_EN = 1'b1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_val_Dhl,
    input  logic          squash_Dhl,
    input  logic          rs_en_Dhl,
    input  logic          rt_en_Dhl,
    input  logic [AW-1:0] rs_Dhl,
    input  logic [AW-1:0] rt_Dhl,
    input  logic          wen_Dhl,
    input  logic [AW-1:0] waddr_Dhl,
    input  logic          is_load_Dhl,
    input  logic          is_muldiv_Dhl,
    input  logic          mem_stall_Mhl,
    input  logic          muldivreq_rdy,
    input  logic          muldivresp_val,
    output logic          muldivreq_val,
    output logic          muldivresp_rdy,
    output logic [1:0]    op0_byp_mux_sel_Dhl,
    output logic [1:0]    op1_byp_mux_sel_Dhl,
    output logic          stall_Fhl,
    output logic          stall_Dhl,
    output logic          stall_Xhl,
    output logic          stall_Mhl,
    output logic          stall_Whl,
    output logic          rf_wen_Whl,
    output logic [AW-1:0] rf_waddr_Whl
);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t md_state_q, md_state_d;

    // Stage tracking; only X needs the load/muldiv flags since later stages
    // always hold their final result on the bypass network.
    logic          val_X, wen_X, is_load_X, is_muldiv_X;
    logic [AW-1:0] waddr_X;
    logic          val_M, wen_M;
    logic [AW-1:0] waddr_M;
    logic          val_W, wen_W;
    logic [AW-1:0] waddr_W;

    logic rs_x, rs_m, rs_w, rt_x, rt_m, rt_w;
    logic hz, mdstall;

    // A stage supplies register r when it holds a live write to it; r0 never does.
    function automatic logic match(input logic v, input logic w,
                                   input logic [AW-1:0] wa, input logic [AW-1:0] r);
        return v & w & (wa == r) & (r != '0);
    endfunction

    // Youngest writer wins; with bypassing disabled operands always come from the RF.
    function automatic logic [1:0] byp_sel(input logic x, input logic m, input logic w);
        logic [1:0] s;
        s = 2'b00;
        if (BYP_EN) begin
            if (x)      s = 2'b01;
            else if (m) s = 2'b10;
            else if (w) s = 2'b11;
        end
        return s;
    endfunction

    // Source/destination matching, bypass selects and hazard detection.
    always_comb begin
        rs_x = rs_en_Dhl & match(val_X, wen_X, waddr_X, rs_Dhl);
        rs_m = rs_en_Dhl & match(val_M, wen_M, waddr_M, rs_Dhl);
        rs_w = rs_en_Dhl & match(val_W, wen_W, waddr_W, rs_Dhl);
        rt_x = rt_en_Dhl & match(val_X, wen_X, waddr_X, rt_Dhl);
        rt_m = rt_en_Dhl & match(val_M, wen_M, waddr_M, rt_Dhl);
        rt_w = rt_en_Dhl & match(val_W, wen_W, waddr_W, rt_Dhl);
        op0_byp_mux_sel_Dhl = byp_sel(rs_x, rs_m, rs_w);
        op1_byp_mux_sel_Dhl = byp_sel(rt_x, rt_m, rt_w);
        hz = ((rs_x | rt_x) & (is_load_X | is_muldiv_X))
           | (!BYP_EN & (rs_x | rs_m | rs_w | rt_x | rt_m | rt_w));
    end

    // Stall chain: a stage stalls whenever anything younger-facing must hold.
    always_comb begin
        stall_Whl = 1'b0;
        stall_Mhl = mem_stall_Mhl & val_M;
        mdstall   = val_X & is_muldiv_X
                  & !((md_state_q == MD_BUSY) & muldivresp_val & !stall_Mhl);
        stall_Xhl = stall_Mhl | mdstall;
        stall_Dhl = stall_Xhl | (inst_val_Dhl & hz & !squash_Dhl);
        stall_Fhl = stall_Dhl;
    end

    // Muldiv handshake state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) md_state_q <= MD_IDLE;
        else       md_state_q <= md_state_d;
    end

    // Muldiv next state and request/response handshake signals.
    always_comb begin
        md_state_d     = md_state_q;
        muldivreq_val  = 1'b0;
        muldivresp_rdy = 1'b0;
        case (md_state_q)
            MD_IDLE: begin
                muldivreq_val = val_X & is_muldiv_X;
                if (muldivreq_val & muldivreq_rdy) md_state_d = MD_BUSY;
            end
            MD_BUSY: begin
                muldivresp_rdy = !stall_Mhl;
                if (muldivresp_val & muldivresp_rdy) md_state_d = MD_IDLE;
            end
            default: md_state_d = MD_IDLE;
        endcase
    end

    // Advance tracking registers, inserting bubbles behind any stalled stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_X       <= 1'b0;
            wen_X       <= 1'b0;
            waddr_X     <= '0;
            is_load_X   <= 1'b0;
            is_muldiv_X <= 1'b0;
            val_M       <= 1'b0;
            wen_M       <= 1'b0;
            waddr_M     <= '0;
            val_W       <= 1'b0;
            wen_W       <= 1'b0;
            waddr_W     <= '0;
        end else begin
            if (!stall_Xhl) begin
                val_X       <= inst_val_Dhl & !stall_Dhl & !squash_Dhl;
                wen_X       <= wen_Dhl;
                waddr_X     <= waddr_Dhl;
                is_load_X   <= is_load_Dhl;
                is_muldiv_X <= is_muldiv_Dhl;
            end
            if (!stall_Mhl) begin
                val_M   <= val_X & !stall_Xhl;
                wen_M   <= wen_X;
                waddr_M <= waddr_X;
            end
            val_W   <= val_M & !stall_Mhl;
            wen_W   <= wen_M;
            waddr_W <= waddr_M;
        end
    end

    // Regfile write port driven from W.
    always_comb begin
        rf_wen_Whl   = val_W & wen_W;
        rf_waddr_Whl = waddr_W;
    end

endmodule

// File: tb/tb_pv2byp_hazard_sched.sv
// Directed bench for pv2byp_hazard_sched: bypass selection, load-use stall,
// muldiv sequencing, r0 handling, squash, mem stall during muldiv, reset in BUSY.
module tb_pv2byp_hazard_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       inst_val_Dhl, squash_Dhl, rs_en_Dhl, rt_en_Dhl;
    logic [4:0] rs_Dhl, rt_Dhl, waddr_Dhl;
    logic       wen_Dhl, is_load_Dhl, is_muldiv_Dhl;
    logic       mem_stall_Mhl, muldivreq_rdy, muldivresp_val;
    logic       muldivreq_val, muldivresp_rdy;
    logic [1:0] op0_byp_mux_sel_Dhl, op1_byp_mux_sel_Dhl;
    logic       stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl;
    logic       rf_wen_Whl;
    logic [4:0] rf_waddr_Whl;

    int checks = 0;
    int errors = 0;
    int xs_cnt = 0;
    int hs_cnt = 0;

    pv2byp_hazard_sched dut (
        .clk                 (clk),
        .reset               (reset),
        .inst_val_Dhl        (inst_val_Dhl),
        .squash_Dhl          (squash_Dhl),
        .rs_en_Dhl           (rs_en_Dhl),
        .rt_en_Dhl           (rt_en_Dhl),
        .rs_Dhl              (rs_Dhl),
        .rt_Dhl              (rt_Dhl),
        .wen_Dhl             (wen_Dhl),
        .waddr_Dhl           (waddr_Dhl),
        .is_load_Dhl         (is_load_Dhl),
        .is_muldiv_Dhl       (is_muldiv_Dhl),
        .mem_stall_Mhl       (mem_stall_Mhl),
        .muldivreq_rdy       (muldivreq_rdy),
        .muldivresp_val      (muldivresp_val),
        .muldivreq_val       (muldivreq_val),
        .muldivresp_rdy      (muldivresp_rdy),
        .op0_byp_mux_sel_Dhl (op0_byp_mux_sel_Dhl),
        .op1_byp_mux_sel_Dhl (op1_byp_mux_sel_Dhl),
        .stall_Fhl           (stall_Fhl),
        .stall_Dhl           (stall_Dhl),
        .stall_Xhl           (stall_Xhl),
        .stall_Mhl           (stall_Mhl),
        .stall_Whl           (stall_Whl),
        .rf_wen_Whl          (rf_wen_Whl),
        .rf_waddr_Whl        (rf_waddr_Whl)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dinst(input logic v, input logic rse, input logic [4:0] rs,
                         input logic rte, input logic [4:0] rt, input logic we,
                         input logic [4:0] wa, input logic ld, input logic md);
        inst_val_Dhl  = v;
        rs_en_Dhl     = rse;
        rs_Dhl        = rs;
        rt_en_Dhl     = rte;
        rt_Dhl        = rt;
        wen_Dhl       = we;
        waddr_Dhl     = wa;
        is_load_Dhl   = ld;
        is_muldiv_Dhl = md;
    endtask

    task automatic idle();
        dinst(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        reset          = 1'b1;
        squash_Dhl     = 1'b0;
        mem_stall_Mhl  = 1'b0;
        muldivreq_rdy  = 1'b0;
        muldivresp_val = 1'b0;
        idle();
        #2;
        // reset state
        chk("rst_sel0", op0_byp_mux_sel_Dhl, 2'b00);
        chk("rst_sel1", op1_byp_mux_sel_Dhl, 2'b00);
        chk("rst_stallF", stall_Fhl, 1'b0);
        chk("rst_stallD", stall_Dhl, 1'b0);
        chk("rst_stallX", stall_Xhl, 1'b0);
        chk("rst_stallM", stall_Mhl, 1'b0);
        chk("rst_stallW", stall_Whl, 1'b0);
        chk("rst_reqval", muldivreq_val, 1'b0);
        chk("rst_resprdy", muldivresp_rdy, 1'b0);
        chk("rst_rfwen", rf_wen_Whl, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // 1: back-to-back ALU dependence, X/M/W bypass
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd2, 0, 0); #1;
        chk("t1_addiu_sel0", op0_byp_mux_sel_Dhl, 2'b00);
        chk("t1_addiu_stallD", stall_Dhl, 1'b0);
        tick();
        dinst(1, 1, 5'd2, 1, 5'd2, 1, 5'd3, 0, 0); #1;
        chk("t1_addu_sel0", op0_byp_mux_sel_Dhl, 2'b01);
        chk("t1_addu_sel1", op1_byp_mux_sel_Dhl, 2'b01);
        chk("t1_addu_stallD", stall_Dhl, 1'b0);
        tick();
        dinst(1, 1, 5'd2, 1, 5'd3, 0, 5'd0, 0, 0); #1;
        chk("t1_c_sel0_M", op0_byp_mux_sel_Dhl, 2'b10);
        chk("t1_c_sel1_X", op1_byp_mux_sel_Dhl, 2'b01);
        chk("t1_c_rfwen", rf_wen_Whl, 1'b0);
        tick();
        dinst(1, 1, 5'd2, 1, 5'd3, 0, 5'd0, 0, 0); #1;
        chk("t1_d_sel0_W", op0_byp_mux_sel_Dhl, 2'b11);
        chk("t1_d_sel1_M", op1_byp_mux_sel_Dhl, 2'b10);
        chk("t1_w_r2_wen", rf_wen_Whl, 1'b1);
        chk("t1_w_r2_addr", rf_waddr_Whl, 5'd2);
        tick();
        idle(); #1;
        chk("t1_w_r3_wen", rf_wen_Whl, 1'b1);
        chk("t1_w_r3_addr", rf_waddr_Whl, 5'd3);
        tick(); #1;
        chk("t1_w_nowrite", rf_wen_Whl, 1'b0);
        drain();

        // 2: load-use stall for one cycle, then bypass from M
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd4, 1, 0); #1;
        chk("t2_lw_stallD", stall_Dhl, 1'b0);
        tick();
        dinst(1, 1, 5'd4, 1, 5'd0, 1, 5'd7, 0, 0); #1;
        chk("t2_use_stallD", stall_Dhl, 1'b1);
        chk("t2_use_stallF", stall_Fhl, 1'b1);
        chk("t2_use_stallX", stall_Xhl, 1'b0);
        tick(); #1;
        chk("t2_retry_stallD", stall_Dhl, 1'b0);
        chk("t2_retry_sel0", op0_byp_mux_sel_Dhl, 2'b10);
        chk("t2_retry_sel1", op1_byp_mux_sel_Dhl, 2'b00);
        tick();
        idle(); #1;
        chk("t2_w_lw_wen", rf_wen_Whl, 1'b1);
        chk("t2_w_lw_addr", rf_waddr_Whl, 5'd4);
        tick(); #1;
        chk("t2_w_bubble", rf_wen_Whl, 1'b0);
        tick(); #1;
        chk("t2_w_addu_wen", rf_wen_Whl, 1'b1);
        chk("t2_w_addu_addr", rf_waddr_Whl, 5'd7);
        drain();

        // 3: muldiv with a 33-cycle latency
        muldivreq_rdy = 1'b1;
        dinst(1, 1, 5'd2, 1, 5'd3, 1, 5'd5, 0, 1); #1;
        chk("t3_d_reqval", muldivreq_val, 1'b0);
        tick();
        idle(); #1;
        chk("t3_hs_reqval", muldivreq_val, 1'b1);
        chk("t3_hs_stallD", stall_Dhl, 1'b1);
        if (stall_Xhl) xs_cnt++;
        if (muldivreq_val && muldivreq_rdy) hs_cnt++;
        tick();
        for (int i = 0; i < 33; i++) begin
            #1;
            if (stall_Xhl) xs_cnt++;
            if (muldivreq_val && muldivreq_rdy) hs_cnt++;
            tick();
        end
        muldivresp_val = 1'b1; #1;
        chk("t3_resp_rdy", muldivresp_rdy, 1'b1);
        chk("t3_resp_stallX", stall_Xhl, 1'b0);
        if (stall_Xhl) xs_cnt++;
        if (muldivreq_val && muldivreq_rdy) hs_cnt++;
        chk("t3_stallX_cycles", 32'(xs_cnt), 32'd34);
        chk("t3_handshakes", 32'(hs_cnt), 32'd1);
        tick();
        muldivresp_val = 1'b0; #1;
        chk("t3_w_bubble", rf_wen_Whl, 1'b0);
        tick(); #1;
        chk("t3_w_mul_wen", rf_wen_Whl, 1'b1);
        chk("t3_w_mul_addr", rf_waddr_Whl, 5'd5);
        drain();

        // 4: r0 is never bypassed or stalled on; youngest writer wins
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0);
        tick();
        dinst(1, 1, 5'd0, 1, 5'd0, 1, 5'd6, 0, 0); #1;
        chk("t4_r0_sel0", op0_byp_mux_sel_Dhl, 2'b00);
        chk("t4_r0_sel1", op1_byp_mux_sel_Dhl, 2'b00);
        chk("t4_r0_stallD", stall_Dhl, 1'b0);
        tick();
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd6, 0, 0);
        tick();
        dinst(1, 1, 5'd6, 0, 5'd6, 0, 5'd0, 0, 0); #1;
        chk("t4_youngest_sel0", op0_byp_mux_sel_Dhl, 2'b01);
        chk("t4_rten0_sel1", op1_byp_mux_sel_Dhl, 2'b00);
        tick();
        drain();

        // squash while hazard-stalled: squash wins, D instruction never writes
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd13, 1, 0);
        tick();
        dinst(1, 1, 5'd13, 0, 5'd0, 1, 5'd14, 0, 0);
        squash_Dhl = 1'b1; #1;
        chk("sq_stallD", stall_Dhl, 1'b0);
        tick();
        squash_Dhl = 1'b0;
        dinst(1, 1, 5'd13, 0, 5'd0, 0, 5'd0, 0, 0); #1;
        chk("sq_next_sel0", op0_byp_mux_sel_Dhl, 2'b10);
        tick();
        idle(); #1;
        chk("sq_w_lw_addr", rf_waddr_Whl, 5'd13);
        tick(); #1;
        chk("sq_w_killed", rf_wen_Whl, 1'b0);
        drain();

        // 5: mem stall for 3 cycles with a muldiv response pending
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd9, 1, 0);
        tick();
        dinst(1, 1, 5'd2, 0, 5'd0, 1, 5'd8, 0, 1); #1;
        chk("t5_stallX_pre", stall_Xhl, 1'b0);
        tick();
        idle();
        mem_stall_Mhl = 1'b1; #1;
        chk("t5_stallM", stall_Mhl, 1'b1);
        chk("t5_hs_reqval", muldivreq_val, 1'b1);
        chk("t5_hs_resprdy", muldivresp_rdy, 1'b0);
        tick();
        muldivresp_val = 1'b1; #1;
        chk("t5_ms1_resprdy", muldivresp_rdy, 1'b0);
        chk("t5_ms1_stallX", stall_Xhl, 1'b1);
        chk("t5_ms1_rfwen", rf_wen_Whl, 1'b0);
        tick(); #1;
        chk("t5_ms2_resprdy", muldivresp_rdy, 1'b0);
        chk("t5_ms2_busy", muldivreq_val, 1'b0);
        chk("t5_ms2_rfwen", rf_wen_Whl, 1'b0);
        tick();
        mem_stall_Mhl = 1'b0; #1;
        chk("t5_rel_resprdy", muldivresp_rdy, 1'b1);
        chk("t5_rel_stallX", stall_Xhl, 1'b0);
        tick();
        muldivresp_val = 1'b0; #1;
        chk("t5_w_lw_addr", rf_waddr_Whl, 5'd9);
        chk("t5_w_lw_wen", rf_wen_Whl, 1'b1);
        tick(); #1;
        chk("t5_w_mul_wen", rf_wen_Whl, 1'b1);
        chk("t5_w_mul_addr", rf_waddr_Whl, 5'd8);
        drain();

        // 6: reset during BUSY, late response ignored, clean restart
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd11, 0, 0);
        tick();
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd10, 0, 1);
        tick();
        idle(); #1;
        chk("t6_hs_reqval", muldivreq_val, 1'b1);
        tick(); #1;
        chk("t6_busy_stallX", stall_Xhl, 1'b1);
        chk("t6_busy_w_addr", rf_waddr_Whl, 5'd11);
        chk("t6_busy_w_wen", rf_wen_Whl, 1'b1);
        muldivresp_val = 1'b1;
        reset = 1'b1; #1;
        chk("t6_rst_stallF", stall_Fhl, 1'b0);
        chk("t6_rst_stallD", stall_Dhl, 1'b0);
        chk("t6_rst_stallX", stall_Xhl, 1'b0);
        chk("t6_rst_reqval", muldivreq_val, 1'b0);
        chk("t6_rst_resprdy", muldivresp_rdy, 1'b0);
        chk("t6_rst_rfwen", rf_wen_Whl, 1'b0);
        tick();
        reset = 1'b0; #1;
        chk("t6_late_resprdy", muldivresp_rdy, 1'b0);
        tick();
        muldivresp_val = 1'b0;
        dinst(1, 1, 5'd0, 0, 5'd0, 1, 5'd12, 0, 0);
        tick();
        idle();
        tick();
        tick(); #1;
        chk("t6_restart_wen", rf_wen_Whl, 1'b1);
        chk("t6_restart_addr", rf_waddr_Whl, 5'd12);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
